// File: rtl/beta_bypass_scoreboard.sv
// rtl/beta_bypass_scoreboard.sv - operand bypass and load-use interlock for the pipelined Beta
//
// Tracks destination tags of in-flight instructions (EX..WB). Each decode read
// port gets the youngest in-flight result for its address. If that producer has
// no result yet, stall is raised.
//
// Optional feature macro: BYPASS_STALL_STATS_EN (adds stall_cnt / fwd_cnt outputs)
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   rd_addr  [NRD*AW]    decode read addresses, port p at [p*AW +: AW]
//   rd_use   [NRD]       port p operand is consumed by the decode instruction
//   rf_data  [NRD*DW]    register-file read data per port
//   stg_data [NSTG*DW]   result bus per tracked stage (0=EX, 1=MEM, NSTG-1=WB)
//   id_valid, id_wr      decode holds a real instruction / it writes a register
//   id_dest  [AW]        decode destination register
//   id_rdy   [2]         first stage index whose stg_data carries the result
//   flush                annul the decode instruction
//   rd_data  [NRD*DW]    bypassed operand per port
//   stall                hold PC/IF/ID, insert bubble into EX
//   stall_cnt, fwd_cnt   (BYPASS_STALL_STATS_EN only) saturating event counters
module beta_bypass_scoreboard #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int NRD      = 2,
    parameter int NSTG     = 3,
    parameter int ZERO_REG = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NRD*AW-1:0] rd_addr,
    input  logic [NRD-1:0]    rd_use,
    input  logic [NRD*DW-1:0] rf_data,
    input  logic [NSTG*DW-1:0] stg_data,
    input  logic              id_valid,
    input  logic              id_wr,
    input  logic [AW-1:0]     id_dest,
    input  logic [1:0]        id_rdy,
    input  logic              flush,
    output logic [NRD*DW-1:0] rd_data,
    output logic              stall
`ifdef BYPASS_STALL_STATS_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       fwd_cnt
`endif
);

    localparam logic [AW-1:0] ZREG    = AW'(ZERO_REG);
    localparam logic [1:0]    RDY_MAX = 2'(NSTG - 1);

    // Tag pipeline: index 0 is the youngest (EX) instruction.
    logic [NSTG-1:0] vld;
    logic [AW-1:0]   dest [NSTG];
    logic [1:0]      rdy  [NSTG];

    logic [NSTG-1:0] match [NRD];
    logic [NRD-1:0]  hazard;
    logic [1:0]      rdy_in;
    logic            enter_vld;

    // A producer that cannot deliver before WB is treated as a WB producer so
    // the interlock always resolves.
    always_comb begin
        rdy_in = id_rdy;
        if (int'(id_rdy) >= NSTG) begin
            rdy_in = RDY_MAX;
        end
    end

    always_comb begin
        for (int p = 0; p < NRD; p++) begin
            match[p] = '0;
            for (int s = 0; s < NSTG; s++) begin
                match[p][s] = vld[s] && (dest[s] == rd_addr[p*AW +: AW]) &&
                              (rd_addr[p*AW +: AW] != ZREG);
            end
        end
    end

    // Walk oldest to youngest so the youngest matching stage wins; older
    // writers of the same register are architecturally stale.
    always_comb begin
        rd_data = rf_data;
        hazard  = '0;
        for (int p = 0; p < NRD; p++) begin
            for (int s = NSTG - 1; s >= 0; s--) begin
                if (match[p][s]) begin
                    rd_data[p*DW +: DW] = stg_data[s*DW +: DW];
                    hazard[p]           = (int'(rdy[s]) > s) && rd_use[p] && id_valid;
                end
            end
        end
    end

    assign stall     = !reset && !flush && (|hazard);
    assign enter_vld = id_valid && id_wr && (id_dest != ZREG) && !stall && !flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld <= '0;
            for (int s = 0; s < NSTG; s++) begin
                dest[s] <= '0;
                rdy[s]  <= '0;
            end
        end else begin
            vld[0]  <= enter_vld;
            dest[0] <= id_dest;
            rdy[0]  <= rdy_in;
            for (int s = 1; s < NSTG; s++) begin
                vld[s]  <= vld[s-1];
                dest[s] <= dest[s-1];
                rdy[s]  <= rdy[s-1];
            end
        end
    end

`ifdef BYPASS_STALL_STATS_EN
    logic any_fwd;

    always_comb begin
        any_fwd = 1'b0;
        for (int p = 0; p < NRD; p++) begin
            if (rd_use[p] && (|match[p])) begin
                any_fwd = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else begin
            if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (any_fwd && (fwd_cnt != 32'hFFFF_FFFF)) begin
                fwd_cnt <= fwd_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_beta_bypass_scoreboard.sv
// tb/tb_beta_bypass_scoreboard.sv - directed self-checking bench for beta_bypass_scoreboard
module tb_beta_bypass_scoreboard;

    logic        clk;
    logic        reset;
    logic [4:0]  a0, a1;
    logic [1:0]  use_v;
    logic [31:0] rf0, rf1;
    logic [31:0] s0d, s1d, s2d;
    logic        id_valid, id_wr, flush;
    logic [4:0]  id_dest;
    logic [1:0]  id_rdy;
    logic [63:0] rd_data;
    logic        stall;
    logic [31:0] d0, d1;
`ifdef BYPASS_STALL_STATS_EN
    logic [31:0] stall_cnt, fwd_cnt;
`endif

    int ntotal = 0;
    int npass  = 0;
    int nfail  = 0;

    assign d0 = rd_data[31:0];
    assign d1 = rd_data[63:32];

    beta_bypass_scoreboard dut (
        .clk      (clk),
        .reset    (reset),
        .rd_addr  ({a1, a0}),
        .rd_use   (use_v),
        .rf_data  ({rf1, rf0}),
        .stg_data ({s2d, s1d, s0d}),
        .id_valid (id_valid),
        .id_wr    (id_wr),
        .id_dest  (id_dest),
        .id_rdy   (id_rdy),
        .flush    (flush),
        .rd_data  (rd_data),
        .stall    (stall)
`ifdef BYPASS_STALL_STATS_EN
        ,
        .stall_cnt(stall_cnt),
        .fwd_cnt  (fwd_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic id(input logic v, input logic w, input logic [4:0] d, input logic [1:0] r);
        id_valid = v;
        id_wr    = w;
        id_dest  = d;
        id_rdy   = r;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; use_v = 2'b00;
        a0 = 5'd1; a1 = 5'd2;
        rf0 = 32'h1111_1111; rf1 = 32'h2222_2222;
        s0d = 32'h0000_00A5; s1d = 32'hDEAD_BEEF; s2d = 32'h0000_0777;
        id(1'b0, 1'b0, 5'd0, 2'd0);
        #2;
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_rd0", d0, 32'h1111_1111);
        chk("rst_rd1", d1, 32'h2222_2222);
        tick; tick;
        reset = 1'b0;

        // ADD r1 then SUB r10,r1,r9 : ALU result forwarded, no stall
        a0 = 5'd7; a1 = 5'd8; use_v = 2'b11; id(1'b1, 1'b1, 5'd1, 2'd0);
        #1 chk("add_nostall", {31'b0, stall}, 32'd0);
        tick;                                   // s0=r1
        a0 = 5'd1; a1 = 5'd9; id(1'b1, 1'b1, 5'd10, 2'd0);
        #1;
        chk("alu_fwd_stall", {31'b0, stall}, 32'd0);
        chk("alu_fwd_rd0", d0, 32'h0000_00A5);
        chk("alu_fwd_rd1", d1, 32'h2222_2222);
        tick;                                   // s0=r10 s1=r1

        // LD r2 (rdy 1) then ADD r3,r2,r2 : one stall cycle
        a0 = 5'd20; a1 = 5'd21; use_v = 2'b01; id(1'b1, 1'b1, 5'd2, 2'd1);
        #1 chk("ld_issue_stall", {31'b0, stall}, 32'd0);
        tick;                                   // s0=r2(rdy1) s1=r10 s2=r1
        a0 = 5'd2; a1 = 5'd2; use_v = 2'b11; id(1'b1, 1'b1, 5'd3, 2'd0);
        #1;
        chk("ld_use_stall", {31'b0, stall}, 32'd1);
        chk("ld_use_same0", d0, 32'h0000_00A5);
        chk("ld_use_same1", d1, 32'h0000_00A5);
        tick;                                   // s0=bubble s1=r2 s2=r10
        chk("ld_use_release", {31'b0, stall}, 32'd0);
        chk("ld_mem_rd0", d0, 32'hDEAD_BEEF);
        chk("ld_mem_rd1", d1, 32'hDEAD_BEEF);
`ifdef BYPASS_STALL_STATS_EN
        chk("stall_cnt_1", stall_cnt, 32'd1);
`endif
        a1 = 5'd3; use_v = 2'b01;
        #1 chk("bubble_in_ex", d1, 32'h2222_2222);
        a1 = 5'd2; use_v = 2'b11;
        tick;                                   // s0=r3 s1=bubble s2=r2

        // r4 written twice back-to-back: EX copy beats MEM copy
        a0 = 5'd0; a1 = 5'd0; use_v = 2'b00; id(1'b1, 1'b1, 5'd4, 2'd0);
        tick;                                   // s0=r4 s1=r3 s2=bubble
        tick;                                   // s0=r4 s1=r4 s2=r3
        s0d = 32'h0000_0001; s1d = 32'h0000_0002;
        a0 = 5'd3; a1 = 5'd4; use_v = 2'b11; id(1'b0, 1'b0, 5'd0, 2'd0);
        #1;
        chk("youngest_stall", {31'b0, stall}, 32'd0);
        chk("youngest_rd1", d1, 32'h0000_0001);
        chk("wb_fwd_rd0", d0, 32'h0000_0777);

        // Write r31 with rdy 1, then read r31 on both ports
        a0 = 5'd0; a1 = 5'd0; use_v = 2'b00; id(1'b1, 1'b1, 5'd31, 2'd1);
        tick;                                   // s0=bubble s1=r4 s2=r4
        rf0 = 32'h0; rf1 = 32'h0;
        a0 = 5'd31; a1 = 5'd31; use_v = 2'b11; id(1'b1, 1'b0, 5'd0, 2'd0);
        #1;
        chk("zero_stall", {31'b0, stall}, 32'd0);
        chk("zero_rd0", d0, 32'h0);
        chk("zero_rd1", d1, 32'h0);
        rf0 = 32'h1111_1111; rf1 = 32'h2222_2222;
        tick;                                   // s0=bubble s1=bubble s2=r4

        // LD r5 with id_rdy=3 (clamped to WB), rd_use/id_valid/flush gating
        a0 = 5'd0; a1 = 5'd0; use_v = 2'b00; id(1'b1, 1'b1, 5'd5, 2'd3);
        tick;                                   // s0=r5(rdy2)
        a0 = 5'd5; a1 = 5'd0; use_v = 2'b00; id(1'b1, 1'b1, 5'd11, 2'd0);
        #1;
        chk("nouse_stall", {31'b0, stall}, 32'd0);
        chk("nouse_fwd", d0, 32'h0000_0001);
        use_v = 2'b01;
        #1 chk("use_stall", {31'b0, stall}, 32'd1);
        id_valid = 1'b0;
        #1 chk("novalid_stall", {31'b0, stall}, 32'd0);
        id(1'b1, 1'b1, 5'd6, 2'd0); flush = 1'b1;
        #1 chk("flush_stall", {31'b0, stall}, 32'd0);
        tick;                                   // s0=bubble(r6 annulled) s1=r5 s2=bubble
        flush = 1'b0;
        a0 = 5'd5; a1 = 5'd6; use_v = 2'b11; id(1'b1, 1'b1, 5'd11, 2'd0);
        #1;
        chk("clamp_stall", {31'b0, stall}, 32'd1);
        chk("clamp_mem_rd0", d0, 32'h0000_0002);
        chk("flush_bubble_rd1", d1, 32'h2222_2222);
        tick;                                   // s0=bubble s1=bubble s2=r5
        chk("clamp_release", {31'b0, stall}, 32'd0);
        chk("clamp_wb_rd0", d0, 32'h0000_0777);
`ifdef BYPASS_STALL_STATS_EN
        chk("stall_cnt_2", stall_cnt, 32'd2);
`endif
        tick;                                   // s0=r11

        // LD r7 (rdy 2), consumer stalls, reset arrives mid-stall
        a0 = 5'd0; a1 = 5'd0; use_v = 2'b00; id(1'b1, 1'b1, 5'd7, 2'd2);
        tick;                                   // s0=r7(rdy2) s1=r11
        a0 = 5'd7; a1 = 5'd0; use_v = 2'b01; id(1'b1, 1'b1, 5'd12, 2'd0);
        #1 chk("ld2_stall_a", {31'b0, stall}, 32'd1);
        tick;                                   // s0=bubble s1=r7(rdy2)
        chk("ld2_stall_b", {31'b0, stall}, 32'd1);
`ifdef BYPASS_STALL_STATS_EN
        chk("stall_cnt_3", stall_cnt, 32'd3);
`endif
        reset = 1'b1;
        #1;
        chk("midrst_stall", {31'b0, stall}, 32'd0);
        chk("midrst_rd0", d0, 32'h1111_1111);
`ifdef BYPASS_STALL_STATS_EN
        chk("midrst_stall_cnt", stall_cnt, 32'd0);
        chk("midrst_fwd_cnt", fwd_cnt, 32'd0);
`endif
        tick;
        reset = 1'b0;
        id(1'b0, 1'b0, 5'd0, 2'd0);
        #1;
        chk("postrst_stall", {31'b0, stall}, 32'd0);
        chk("postrst_rd0", d0, 32'h1111_1111);
        tick;
        chk("postrst_rd0_b", d0, 32'h1111_1111);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
